// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: Diff = A - B - Bin, one full-subtractor step per clock, LSB first.
// Optional signed-overflow flag Ovf is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         Zero
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         Ovf
`endif
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e         state_q;
    logic [N-1:0]   a_sh_q;
    logic [N-1:0]   b_sh_q;
    logic [N-1:0]   res_q;
    logic [N-1:0]   diff_q;
    logic [CW-1:0]  cnt_q;
    logic           br_q;
    logic           bout_q;
    logic           zero_q;
    logic           busy_q;
    logic           done_q;
    logic           d_bit;
    logic           br_d;

`ifdef SERIAL_SUB_OVF_EN
    logic           a_msb_q;
    logic           b_msb_q;
    logic           ovf_q;
`endif

    // Single full-subtractor cell working on the current LSBs.
    always_comb begin
        d_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_d  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= A;
                        b_sh_q  <= B;
                        br_q    <= Bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= A[N-1];
                        b_msb_q <= B[N-1];
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    if (cnt_q == CW'(N)) begin
                        // All N bits consumed: publish the result with the done pulse.
                        diff_q  <= res_q;
                        bout_q  <= br_q;
                        zero_q  <= (res_q == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= (a_msb_q != b_msb_q) && (res_q[N-1] != a_msb_q);
`endif
                    end else begin
                        a_sh_q <= a_sh_q >> 1;
                        b_sh_q <= b_sh_q >> 1;
                        res_q  <= {d_bit, res_q[N-1:1]};
                        br_q   <= br_d;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Diff = diff_q;
    assign Bout = bout_q;
    assign Zero = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule
